// File: rtl/arbitro_mux4_if.sv
// Purpose: request/grant bundle between four requesters and the arbiter of a
// shared 4:1 single-bit mux path.
//   i_req   : per-requester level request
//   i_lock  : grant lock (only when ARB_LOCK_EN is defined)
//   o_gnt   : one-hot registered grant, 0 = no grant
//   o_sel   : index of the granted requester (mux select)
//   o_valid : grant present (its inverse gates the mux reset)
// Modports: master = arbiter side, slave = requester side.
interface arbitro_mux4_if;
  logic [3:0] i_req;
`ifdef ARB_LOCK_EN
  logic       i_lock;
`endif
  logic [3:0] o_gnt;
  logic [1:0] o_sel;
  logic       o_valid;

  modport master (
`ifdef ARB_LOCK_EN
    input  i_lock,
`endif
    input  i_req,
    output o_gnt,
    output o_sel,
    output o_valid
  );

  modport slave (
`ifdef ARB_LOCK_EN
    output i_lock,
`endif
    output i_req,
    input  o_gnt,
    input  o_sel,
    input  o_valid
  );
endinterface

// File: rtl/arbitro_mux4.sv
// Purpose: round-robin arbiter sharing one 4:1 single-bit mux path among four
// requesters, with a hold limit that rotates the grant under contention.
// Ports:
//   clk  : clock, rising edge
//   rs   : synchronous active-high reset
//   bus  : arbitro_mux4_if.master (i_req, [i_lock], o_gnt, o_sel, o_valid)
// Parameters:
//   MAX_HOLD : max consecutive cycles a grant is kept while others wait (>=1)
//   HOLD_W   : hold counter width, 2**HOLD_W > MAX_HOLD
// Optional feature macro ARB_LOCK_EN: adds i_lock, which suppresses the forced
// rotation while the owner keeps requesting.
module arbitro_mux4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input logic            clk,
  input logic            rs,
  arbitro_mux4_if.master bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e            state_q, state_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        last_q, last_d;
  logic              valid_q, valid_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [3:0]        elig_c;
  logic              pick_ok_c;
  logic [1:0]        pick_idx_c;
  logic              lock_c;

`ifdef ARB_LOCK_EN
  assign lock_c = bus.i_lock;
`else
  assign lock_c = 1'b0;
`endif

  // The current owner never competes against itself for a regrant/rotation.
  assign elig_c = bus.i_req & ((state_q == GRANT) ? ~gnt_q : 4'b1111);

  // Round-robin search from last+1; scanning downward lets the nearest win.
  always_comb begin
    pick_ok_c  = 1'b0;
    pick_idx_c = last_q;
    for (int k = 4; k >= 1; k--) begin
      if (elig_c[2'(last_q + 2'(k))]) begin
        pick_ok_c  = 1'b1;
        pick_idx_c = 2'(last_q + 2'(k));
      end
    end
  end

  // Next-state and output computation.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    valid_d = valid_q;
    hold_d  = hold_q;

    unique case (state_q)
      IDLE: begin
        if (pick_ok_c) begin
          state_d = GRANT;
          gnt_d   = 4'(1) << pick_idx_c;
          sel_d   = pick_idx_c;
          last_d  = pick_idx_c;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!bus.i_req[sel_q]) begin
          // Owner released: hand over without a bubble if anyone waits.
          if (pick_ok_c) begin
            gnt_d  = 4'(1) << pick_idx_c;
            sel_d  = pick_idx_c;
            last_d = pick_idx_c;
            hold_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end else if (hold_q == HOLD_LAST && pick_ok_c && !lock_c) begin
          gnt_d  = 4'(1) << pick_idx_c;
          sel_d  = pick_idx_c;
          last_d = pick_idx_c;
          hold_d = '0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rs) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      last_q  <= 2'd3;
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.o_gnt   = gnt_q;
  assign bus.o_sel   = sel_q;
  assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_arbitro_mux4.sv
// Bench for arbitro_mux4 with MAX_HOLD=4: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model
// every cycle.
module tb_arbitro_mux4;

  localparam int MH = 4;

  logic clk;
  logic rs;
  logic lock_s;
  logic chk_en;
  int   total;
  int   bad;

  arbitro_mux4_if bus ();

  arbitro_mux4 #(.MAX_HOLD(MH), .HOLD_W(4)) dut (
    .clk (clk),
    .rs  (rs),
    .bus (bus)
  );

`ifdef ARB_LOCK_EN
  assign bus.i_lock = lock_s;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: owner index (-1 = none), last winner, cycles owned.
  int         m_owner;
  int         m_last;
  int         m_run;
  logic [1:0] m_sel;
  logic [3:0] m_gnt;

  function automatic int rr_pick(logic [3:0] req, int last, int excl);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (c != excl && req[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [3:0] req;
    logic       lk;
    int         other;
    req = bus.i_req;
    lk  = 1'b0;
`ifdef ARB_LOCK_EN
    lk  = lock_s;
`endif
    if (rs) begin
      m_owner = -1; m_last = 3; m_run = 0; m_sel = 2'd0;
    end else if (m_owner < 0) begin
      other = rr_pick(req, m_last, -1);
      if (other >= 0) begin
        m_owner = other; m_last = other; m_run = 1; m_sel = 2'(other);
      end
    end else begin
      other = rr_pick(req, m_last, m_owner);
      if (!req[m_owner]) begin
        if (other >= 0) begin
          m_owner = other; m_last = other; m_run = 1; m_sel = 2'(other);
        end else begin
          m_owner = -1; m_run = 0;
        end
      end else if (m_run >= MH && other >= 0 && !lk) begin
        m_owner = other; m_last = other; m_run = 1; m_sel = 2'(other);
      end else begin
        m_run = m_run + 1;
      end
    end
    m_gnt = (m_owner < 0) ? 4'b0000 : (4'(1) << m_owner);
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (bus.o_gnt !== m_gnt || bus.o_sel !== m_sel || bus.o_valid !== (m_gnt != 4'b0000)) begin
        bad++;
        $display("FAIL model t=%0t: gnt=%b sel=%0d valid=%b want gnt=%b sel=%0d valid=%b",
                 $time, bus.o_gnt, bus.o_sel, bus.o_valid, m_gnt, m_sel, (m_gnt != 4'b0000));
      end
    end
  end

  task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] s,
                            input logic v);
    total++;
    if (bus.o_gnt !== g || bus.o_sel !== s || bus.o_valid !== v) begin
      bad++;
      $display("FAIL %s: gnt=%b sel=%0d valid=%b want gnt=%b sel=%0d valid=%b",
               name, bus.o_gnt, bus.o_sel, bus.o_valid, g, s, v);
    end
  endtask

  task automatic do_reset();
    rs = 1'b1; bus.i_req = 4'b0000; lock_s = 1'b0;
    @(negedge clk);
    rs = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; chk_en = 1'b0;
    m_owner = -1; m_last = 3; m_run = 0; m_sel = 2'd0; m_gnt = 4'b0000;
    rs = 1'b1; lock_s = 1'b0; bus.i_req = 4'b0000;
    @(negedge clk);
    chk_en = 1'b1;

    // Reset held with all requests active.
    bus.i_req = 4'b1111; rs = 1'b1;
    repeat (2) @(negedge clk);
    expect_out("reset", 4'b0000, 2'd0, 1'b0);
    rs = 1'b0;
    @(negedge clk);
    expect_out("post_reset", 4'b0001, 2'd0, 1'b1);

    // Single requester, then release.
    do_reset();
    bus.i_req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_out("single", 4'b0100, 2'd2, 1'b1);
    end
    bus.i_req = 4'b0000;
    @(negedge clk);
    expect_out("single_release", 4'b0000, 2'd2, 1'b0);

    // Full contention rotation, 4 cycles per grant.
    do_reset();
    bus.i_req = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      expect_out("rotation", 4'(1) << ((k / 4) % 4), 2'((k / 4) % 4), 1'b1);
    end

    // Lone hog keeps the grant.
    do_reset();
    bus.i_req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      expect_out("lone_hog", 4'b0001, 2'd0, 1'b1);
    end

    // Owner drops while requester 3 arrives: direct handoff.
    do_reset();
    bus.i_req = 4'b0001;
    @(negedge clk);
    expect_out("handoff_pre", 4'b0001, 2'd0, 1'b1);
    bus.i_req = 4'b1000;
    @(negedge clk);
    expect_out("handoff", 4'b1000, 2'd3, 1'b1);

    // Reset during the second cycle of grant 0010.
    do_reset();
    bus.i_req = 4'b1111;
    repeat (5) @(negedge clk);
    expect_out("midrst_g1", 4'b0010, 2'd1, 1'b1);
    @(negedge clk);
    rs = 1'b1;
    @(negedge clk);
    expect_out("midrst", 4'b0000, 2'd0, 1'b0);
    rs = 1'b0;
    @(negedge clk);
    expect_out("midrst_restart", 4'b0001, 2'd0, 1'b1);

`ifdef ARB_LOCK_EN
    // Lock holds owner 0 past the hold limit; unlock rotates at once.
    do_reset();
    bus.i_req = 4'b0011; lock_s = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      expect_out("lock_hold", 4'b0001, 2'd0, 1'b1);
    end
    lock_s = 1'b0;
    @(negedge clk);
    expect_out("lock_release", 4'b0010, 2'd1, 1'b1);
`endif

    // Randomized traffic checked by the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) bus.i_req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) lock_s = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    rs = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
